// File: rtl/dnn_pkg.sv
// Shared types and defaults for the inference frame sequencer.
// The optional WAIT watchdog is enabled by DNN_INFER_CTRL_TIMEOUT_EN in dnn_infer_ctrl.
package dnn_pkg;

    localparam int              DEF_DATA_W  = 12;
    localparam int              DEF_N_CLASS = 10;
    localparam int              DEF_N_PIX   = 400;
    localparam logic [11:0]     DEF_ONE_VAL = 12'h400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIAS,
        S_RUN,
        S_WAIT,
        S_SCAN,
        S_RESULT
    } ctrl_state_t;

    // Class i occupies element [i], i.e. bits [i*DEF_DATA_W +: DEF_DATA_W] when flattened.
    typedef logic [DEF_N_CLASS-1:0][DEF_DATA_W-1:0] score_arr_t;

endpackage

// File: rtl/dnn_argmax_seq.sv
// Captures the engine scores and walks them one class per cycle, keeping the
// first index holding the largest signed value.
module dnn_argmax_seq #(
    parameter int DATA_WIDTH = 12,
    parameter int N_CLASS    = 10,
    localparam int IW        = $clog2(N_CLASS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          scan,
    input  logic [N_CLASS*DATA_WIDTH-1:0] scores,
    output logic [IW-1:0]                 best_idx,
    output logic [DATA_WIDTH-1:0]         best_score,
    output logic                          scan_done
);

    logic signed [DATA_WIDTH-1:0] cap [N_CLASS];
    logic [IW-1:0]                idx;

    assign scan_done = scan && (idx == IW'(N_CLASS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CLASS; i++) cap[i] <= '0;
            idx        <= '0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (load) begin
            for (int i = 0; i < N_CLASS; i++) cap[i] <= scores[i*DATA_WIDTH +: DATA_WIDTH];
            idx <= '0;
        end else if (scan) begin
            // Class 0 always seeds the best; later classes replace it only when strictly larger.
            if (idx == '0 || cap[idx] > $signed(best_score)) begin
                best_idx   <= idx;
                best_score <= cap[idx];
            end
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/dnn_infer_ctrl.sv
// Frame sequencer: loads pixels plus bias into memory, runs the engine, returns the argmax.
// Define DNN_INFER_CTRL_TIMEOUT_EN to add a watchdog on the engine's done.
module dnn_infer_ctrl
    import dnn_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEF_DATA_W,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = '0,
    parameter int                    N_PIX       = DEF_N_PIX,
    parameter logic [DATA_WIDTH-1:0] ONE_VAL     = DATA_WIDTH'(DEF_ONE_VAL),
    parameter int                    N_CLASS     = DEF_N_CLASS
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
    ,
    parameter int                    TIMEOUT_CYCLES = 200000
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          dnn_start,
    output logic                          dnn_reset,
    input  logic                          dnn_done,
    input  logic [N_CLASS*DATA_WIDTH-1:0] dnn_out,
    input  logic [ADDR_WIDTH-1:0]         dnn_mem_addr,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_we,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [3:0]                    res_class,
    output logic [DATA_WIDTH-1:0]         res_score,
    output logic                          busy,
    output logic                          err
);

    localparam int CW = $clog2(N_PIX + 1);
    localparam int IW = $clog2(N_CLASS);

    ctrl_state_t           state;
    logic [CW-1:0]         wcnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  eng_sel;
    logic                  accept;
    logic                  load_scores;
    logic                  scan_done;
    logic [IW-1:0]         best_idx;

    assign accept      = pix_valid && pix_ready;
    assign load_scores = (state == S_WAIT) && dnn_done;
    assign busy        = (state != S_IDLE);
    assign res_class   = 4'(best_idx);

    // eng_sel flips with the registered outputs, so the bias write still sees the
    // loader address while the engine takes over from its first WAIT cycle.
    assign mem_addr = eng_sel ? dnn_mem_addr : wr_addr;

`ifdef DNN_INFER_CTRL_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    dnn_argmax_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_CLASS    (N_CLASS)
    ) u_argmax (
        .clk        (clk),
        .rst        (rst),
        .load       (load_scores),
        .scan       (state == S_SCAN),
        .scores     (dnn_out),
        .best_idx   (best_idx),
        .best_score (res_score),
        .scan_done  (scan_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pix_ready <= 1'b0;
            dnn_start <= 1'b0;
            dnn_reset <= 1'b0;
            mem_we    <= 1'b0;
            wr_addr   <= ADDR_BASE_A;
            mem_wdata <= '0;
            wcnt      <= '0;
            eng_sel   <= 1'b0;
            res_valid <= 1'b0;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
            wait_cnt  <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            dnn_start <= 1'b0;
            dnn_reset <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    pix_ready <= 1'b1;
                    if (accept) begin
                        dnn_reset <= 1'b1;
                        mem_we    <= 1'b1;
                        wr_addr   <= ADDR_BASE_A;
                        mem_wdata <= pix_data;
                        wcnt      <= CW'(1);
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
                        err_r     <= 1'b0;
`endif
                        if (N_PIX == 1) begin
                            state     <= S_BIAS;
                            pix_ready <= 1'b0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        wr_addr   <= ADDR_BASE_A + ADDR_WIDTH'(wcnt);
                        mem_wdata <= pix_data;
                        wcnt      <= wcnt + 1'b1;
                        if (wcnt == CW'(N_PIX - 1)) begin
                            state     <= S_BIAS;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                S_BIAS: begin
                    mem_we    <= 1'b1;
                    wr_addr   <= ADDR_BASE_A + ADDR_WIDTH'(N_PIX);
                    mem_wdata <= ONE_VAL;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    dnn_start <= 1'b1;
                    eng_sel   <= 1'b1;
                    state     <= S_WAIT;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                S_WAIT: begin
                    if (dnn_done) begin
                        state <= S_SCAN;
`ifdef DNN_INFER_CTRL_TIMEOUT_EN
                    end else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        dnn_reset <= 1'b1;
                        err_r     <= 1'b1;
                        eng_sel   <= 1'b0;
                        pix_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_SCAN: begin
                    if (scan_done) begin
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        eng_sel   <= 1'b0;
                        pix_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Randomized bench for dnn_infer_ctrl with a frame-level reference model and
// a small engine stand-in that answers dnn_start with scores after a random latency.
module tb_dnn_infer_ctrl;
    import dnn_pkg::*;

    localparam int          N_PIX   = 400;
    localparam int          N_CLASS = 10;
    localparam int          BASE    = 0;
    localparam logic [11:0] ONE     = 12'h400;

    logic         clk;
    logic         rst;
    logic         pix_valid;
    logic         pix_ready;
    logic [11:0]  pix_data;
    logic         dnn_start;
    logic         dnn_reset;
    logic         dnn_done;
    logic [119:0] dnn_out;
    logic [15:0]  dnn_mem_addr;
    logic [15:0]  mem_addr;
    logic         mem_we;
    logic [11:0]  mem_wdata;
    logic         res_valid;
    logic         res_ready;
    logic [3:0]   res_class;
    logic [11:0]  res_score;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    int next_scores [N_CLASS];
    int eng_scores  [N_CLASS];

    // Model of the frame: phase 0 = between frames, 1 = loading, 2 = processing
    int          cyc = 0;
    int          phase, cnt;
    logic        rdy_m, busy_m, rv_on, eng_own, done_seen, prev_rv;
    int          rst_due, start_due, rv_due;
    int          done_cyc, rv_cyc, wr_count;
    logic [59:0] exp_q [$];

    dnn_infer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .dnn_start    (dnn_start),
        .dnn_reset    (dnn_reset),
        .dnn_done     (dnn_done),
        .dnn_out      (dnn_out),
        .dnn_mem_addr (dnn_mem_addr),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_class    (res_class),
        .res_score    (res_score),
        .busy         (busy),
        .err          (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_max();
        int m = eng_scores[0];
        for (int i = 1; i < N_CLASS; i++) if (eng_scores[i] > m) m = eng_scores[i];
        return m;
    endfunction

    function automatic int model_cls();
        int m = model_max();
        for (int i = 0; i < N_CLASS; i++) if (eng_scores[i] == m) return i;
        return 0;
    endfunction

    // ---------------- engine stand-in ----------------
    initial begin
        int         cd;
        int         scram;
        score_arr_t so;
        cd = 0;
        scram = 0;
        dnn_done = 1'b0;
        dnn_out = '0;
        dnn_mem_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            dnn_mem_addr = 16'($urandom);
            if (!rst) begin
                dnn_done = 1'b0;
                cd = 0;
                scram = 0;
            end else begin
                if (dnn_reset) dnn_done = 1'b0;
                if (scram > 0) begin
                    scram--;
                    if (scram == 0) dnn_out = {$urandom, $urandom, $urandom, $urandom};
                end
                if (dnn_start) begin
                    cd = $urandom_range(1, 20);
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        for (int i = 0; i < N_CLASS; i++) begin
                            eng_scores[i] = next_scores[i];
                            so[i] = 12'(next_scores[i]);
                        end
                        dnn_out = so;
                        dnn_done = 1'b1;
                        scram = 1;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic        exp_we;
        logic        accept;
        logic [11:0] es;
        cyc++;
        if (!rst) begin
            phase = 0; cnt = 0; rdy_m = 1'b0; busy_m = 1'b0;
            rv_on = 1'b0; eng_own = 1'b0; done_seen = 1'b0; prev_rv = 1'b0;
            rst_due = -1; start_due = -1; rv_due = -1;
            exp_q.delete();
        end else begin
            chk("pix_ready", 32'(pix_ready), 32'(rdy_m));
            chk("busy", 32'(busy), 32'(busy_m));
            chk("err", 32'(err), 32'(0));
            exp_we = (exp_q.size() > 0) && (exp_q[0][59:28] == 32'(cyc));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                if (mem_we) begin
                    chk("mem_addr_wr", 32'(mem_addr), 32'(exp_q[0][27:12]));
                    chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0][11:0]));
                end
                void'(exp_q.pop_front());
            end
            if (mem_we) wr_count++;
            chk("dnn_reset", 32'(dnn_reset), 32'(cyc == rst_due));
            chk("dnn_start", 32'(dnn_start), 32'(cyc == start_due));
            if (cyc == start_due) eng_own = 1'b1;
            if (eng_own) chk("mem_addr_eng", 32'(mem_addr), 32'(dnn_mem_addr));
            if (eng_own && dnn_done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                rv_due = cyc + N_CLASS + 1;
            end
            if (cyc == rv_due) rv_on = 1'b1;
            chk("res_valid", 32'(res_valid), 32'(rv_on));
            if (res_valid && !prev_rv) rv_cyc = cyc;
            prev_rv = res_valid;
            if (rv_on) begin
                es = 12'(model_max());
                chk("res_class", 32'(res_class), 32'(model_cls()));
                chk("res_score", 32'(res_score), 32'(es));
            end
            accept = pix_valid && rdy_m;
            if (accept) begin
                if (phase == 0) begin
                    rst_due = cyc + 1;
                    phase = 1;
                    wr_count = 0;
                end
                exp_q.push_back({32'(cyc + 1), 16'(BASE + cnt), pix_data});
                cnt++;
                if (cnt == N_PIX) begin
                    exp_q.push_back({32'(cyc + 2), 16'(BASE + N_PIX), ONE});
                    start_due = cyc + 3;
                    phase = 2;
                end
            end
            if (rv_on && res_ready) begin
                phase = 0; cnt = 0; rv_on = 1'b0; eng_own = 1'b0;
                done_seen = 1'b0; rv_due = -1;
            end
            rdy_m = (phase != 2);
            busy_m = (phase != 0);
        end
    end

    // ---------------- drivers ----------------
    task automatic send_pix(input logic [11:0] d, input int gap_pct);
        int   g;
        logic ok;
        for (int k = 0; k < 3 && $urandom_range(0, 99) < gap_pct; k++) begin
            pix_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_data = d;
        g = 0;
        ok = 1'b0;
        while (!ok && g < 2000) begin
            @(negedge clk);
            ok = pix_ready;
            @(posedge clk);
            #1;
            g++;
        end
        pix_valid = 1'b0;
        if (!ok) chk("pix_accept", 32'(ok), 32'(1));
    endtask

    task automatic get_result(input int stall, input logic directed);
        int   g;
        logic seen;
        g = 0;
        seen = 1'b0;
        while (!seen && g < 3000) begin
            @(negedge clk);
            seen = res_valid;
            g++;
        end
        chk("res_valid_seen", 32'(seen), 32'(1));
        if (directed && seen) begin
            chk("directed_class", 32'(res_class), 32'(2));
            chk("directed_score", 32'(res_score), 32'(12'd7));
        end
        if (stall > 0) begin
            pix_valid = 1'b1;
            pix_data = 12'($urandom);
        end
        repeat (stall) @(posedge clk);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        if (directed) begin
            chk("done_to_valid", 32'(rv_cyc - done_cyc), 32'(11));
            chk("frame_writes", 32'(wr_count), 32'(401));
        end
    endtask

    task automatic run_frame(input int gap_pct, input int stall, input int smode);
        int dir_s [N_CLASS] = '{-5, 3, 7, 7, -1, 0, 2, 1, 6, -8};
        for (int i = 0; i < N_CLASS; i++) begin
            if (smode == 0)      next_scores[i] = dir_s[i];
            else if (smode == 1) next_scores[i] = int'($urandom_range(0, 8)) - 4;
            else                 next_scores[i] = int'($urandom_range(0, 4095)) - 2048;
        end
        for (int k = 0; k < N_PIX; k++) send_pix(12'($urandom), gap_pct);
        get_result(stall, smode == 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'(0));
        chk({tag, "_dnn_start"}, 32'(dnn_start), 32'(0));
        chk({tag, "_dnn_reset"}, 32'(dnn_reset), 32'(0));
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        chk({tag, "_res_class"}, 32'(res_class), 32'(0));
        chk({tag, "_res_score"}, 32'(res_score), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_err"}, 32'(err), 32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        res_ready = 1'b0;
        wr_count = 0;
        done_cyc = 0;
        rv_cyc = 0;
        for (int i = 0; i < N_CLASS; i++) begin
            next_scores[i] = 0;
            eng_scores[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_frame(0, 0, 0);
        run_frame(0, 50, 2);
        run_frame(40, 3, 1);
        run_frame(25, $urandom_range(0, 10), 1);

        for (int k = 0; k < 123; k++) send_pix(12'($urandom), 20);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        run_frame(0, 0, 0);
        run_frame(50, $urandom_range(0, 20), 2);
        run_frame(10, 1, 1);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
